// File: rtl/surf_dac_pkg.sv
// Shared constants, frame layout and sequencer states for the DAC load path.
package surf_dac_pkg;

  localparam logic [3:0]  DAC_CMD_WRUPD = 4'b0011;
  localparam int unsigned FRAME_BITS    = 24;
  localparam int unsigned NCH           = 32;
  localparam int unsigned CH_W          = 5;
  localparam int unsigned DAT_W         = 16;
  localparam int unsigned DIV_W         = 4;
  localparam int unsigned HALF_W        = 6;
  localparam int unsigned SYNC_W        = 4;
  localparam int unsigned HALF_LAST     = 2 * FRAME_BITS - 1;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } seq_state_e;

  // One serial word as the DAC expects it, MSB first.
  typedef struct packed {
    logic [3:0]       cmd;
    logic             rsvd;
    logic [2:0]       dac_ch;
    logic [DAT_W-1:0] data;
  } dac_frame_t;

  function automatic dac_frame_t make_frame(input logic [CH_W-1:0]  ch,
                                            input logic [DAT_W-1:0] dat);
    dac_frame_t f;
    f.cmd    = DAC_CMD_WRUPD;
    f.rsvd   = 1'b0;
    f.dac_ch = ch[2:0];
    f.data   = dat;
    return f;
  endfunction

endpackage

// File: rtl/dac_shadow_ram.sv
// 32x16 shadow register file: one synchronous write port, two asynchronous
// read ports (bus readback and sequencer fetch). Contents come up zero from
// device configuration and are deliberately not touched by reset.
module dac_shadow_ram
  import surf_dac_pkg::*;
(
  input  logic             clk_i,
  input  logic             wr_i,
  input  logic [CH_W-1:0]  waddr_i,
  input  logic [DAT_W-1:0] wdat_i,
  input  logic [CH_W-1:0]  raddr_i,
  output logic [DAT_W-1:0] rdat_o,
  input  logic [CH_W-1:0]  faddr_i,
  output logic [DAT_W-1:0] fdat_o
);

  logic [DAT_W-1:0] mem_q [NCH];

  // Write port; a fetch in the same cycle still sees the old word.
  always_ff @(posedge clk_i) begin
    if (wr_i) begin
      mem_q[waddr_i] <= wdat_i;
    end
  end

  assign rdat_o = mem_q[raddr_i];
  assign fdat_o = mem_q[faddr_i];

endmodule

// File: rtl/dac_load_sequencer.sv
// Shadow register file plus the sweep sequencer that shifts all 32 entries
// into four 8-channel serial DACs.
module dac_load_sequencer
  import surf_dac_pkg::*;
#(
  parameter int unsigned SCLK_DIV = 2,
  parameter int unsigned NCHIPS   = 4
) (
  input  logic              clk_i,
  input  logic              nrst_i,
  input  logic              wr_i,
  input  logic [CH_W-1:0]   waddr_i,
  input  logic [DAT_W-1:0]  wdat_i,
  input  logic [CH_W-1:0]   raddr_i,
  output logic [DAT_W-1:0]  rdat_o,
  input  logic              update_i,
  output logic              busy_o,
  output logic              dac_sclk_o,
  output logic              dac_sdi_o,
  output logic [SYNC_W-1:0] dac_sync_n_o
);

  if (SCLK_DIV == 0 || SCLK_DIV > 15) begin : g_bad_sclk_div
    $error("dac_load_sequencer: SCLK_DIV must be in 1..15");
  end
  if (NCHIPS != 4) begin : g_bad_nchips
    $error("dac_load_sequencer: NCHIPS is fixed at 4");
  end

  seq_state_e         state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [HALF_W-1:0]  half_q, half_d;
  logic [CH_W-1:0]    ch_q, ch_d;
  logic               pend_q, pend_d;
  logic               adv_q, adv_d;
  logic [FRAME_BITS-2:0] sr_q, sr_d;
  logic               sclk_q, sclk_d;
  logic               sdi_q, sdi_d;
  logic [SYNC_W-1:0]  sync_n_q, sync_n_d;
  logic               busy_q, busy_d;

  logic [DAT_W-1:0]   fetch_dat_c;
  dac_frame_t         fetch_frame_c;
  logic               div_last_c;

  dac_shadow_ram u_ram (
    .clk_i   (clk_i),
    .wr_i    (wr_i),
    .waddr_i (waddr_i),
    .wdat_i  (wdat_i),
    .raddr_i (raddr_i),
    .rdat_o  (rdat_o),
    .faddr_i (ch_q),
    .fdat_o  (fetch_dat_c)
  );

  assign fetch_frame_c = make_frame(ch_q, fetch_dat_c);
  assign div_last_c    = (div_q == DIV_W'(SCLK_DIV - 1));

  // Next-state and next-output logic for the sweep sequencer.
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    half_d   = half_q;
    ch_d     = ch_q;
    pend_d   = pend_q;
    adv_d    = 1'b0;
    sr_d     = sr_q;
    sclk_d   = sclk_q;
    sdi_d    = sdi_q;
    sync_n_d = sync_n_q;

    // Requests arriving mid-sweep collapse into a single pending sweep.
    if (update_i && (state_q != IDLE)) begin
      pend_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (update_i || pend_q) begin
          pend_d  = 1'b0;
          ch_d    = '0;
          div_d   = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        sdi_d    = fetch_frame_c[FRAME_BITS-1];
        sr_d     = fetch_frame_c[FRAME_BITS-2:0];
        sync_n_d = ~(SYNC_W'(1) << ch_q[CH_W-1:3]);
        sclk_d   = 1'b0;
        div_d    = '0;
        state_d  = SETUP;
      end
      SETUP: begin
        if (div_last_c) begin
          div_d   = '0;
          half_d  = '0;
          sclk_d  = 1'b1;
          state_d = SHIFT;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      SHIFT: begin
        // Move to the next bit one clock after each falling edge.
        if (adv_q) begin
          sdi_d = sr_q[FRAME_BITS-2];
          sr_d  = {sr_q[FRAME_BITS-3:0], 1'b0};
        end
        if (div_last_c) begin
          div_d = '0;
          if (half_q == HALF_W'(HALF_LAST)) begin
            state_d = HOLD;
          end else begin
            half_d = half_q + HALF_W'(1);
            sclk_d = ~sclk_q;
            adv_d  = sclk_q;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      HOLD: begin
        if (div_last_c) begin
          div_d    = '0;
          sync_n_d = '1;
          state_d  = GAP;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      GAP: begin
        if (div_last_c) begin
          div_d = '0;
          if (ch_q == CH_W'(NCH - 1)) begin
            state_d = IDLE;
          end else begin
            ch_d    = ch_q + CH_W'(1);
            state_d = FETCH;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE) || pend_d;
  end

  // State, counters and registered pin outputs; reset abandons any frame.
  always_ff @(posedge clk_i) begin
    if (!nrst_i) begin
      state_q  <= IDLE;
      div_q    <= '0;
      half_q   <= '0;
      ch_q     <= '0;
      pend_q   <= 1'b0;
      adv_q    <= 1'b0;
      sr_q     <= '0;
      sclk_q   <= 1'b0;
      sdi_q    <= 1'b0;
      sync_n_q <= '1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      half_q   <= half_d;
      ch_q     <= ch_d;
      pend_q   <= pend_d;
      adv_q    <= adv_d;
      sr_q     <= sr_d;
      sclk_q   <= sclk_d;
      sdi_q    <= sdi_d;
      sync_n_q <= sync_n_d;
      busy_q   <= busy_d;
    end
  end

  assign busy_o       = busy_q;
  assign dac_sclk_o   = sclk_q;
  assign dac_sdi_o    = sdi_q;
  assign dac_sync_n_o = sync_n_q;

endmodule
